// File: rtl/serializer_10b.sv
// serializer_10b: 10-bit symbol serializer with a one-entry hold buffer.
// Sends alternating K28.5 commas when no data is queued; MSB (bit a) goes out first.
module serializer_10b #(
    parameter logic [9:0] COMMA_NEG = 10'b0011111010,
    parameter logic [9:0] COMMA_POS = 10'b1100000101
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enb,
    input  logic [5:0] i_sym_6b,
    input  logic [3:0] i_sym_4b,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_ser_bit,
    output logic       o_ser_valid,
    output logic       o_sym_start,
    output logic       o_idle
);
    typedef enum logic {OFF = 1'b0, TX = 1'b1} state_t;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] sh_q, sh_d, hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       phase_q, phase_d;
    logic       start_q, start_d;
    logic       idle_q, idle_d;
    logic [9:0] sym;
    logic       accept, ld, bypass, comma;
    always_comb begin
        sym         = {i_sym_6b, i_sym_4b};
        accept      = i_valid && !hold_full_q;
        ld          = (state_q == TX && cnt_q == 4'd9) || (state_q == OFF && i_enb);
        bypass      = accept && ld && i_enb;
        comma       = !hold_full_q && !bypass;
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        hold_d      = accept && !bypass ? sym : hold_q;
        hold_full_d = hold_full_q || (accept && !bypass);
        phase_d     = phase_q;
        start_d     = 1'b0;
        idle_d      = idle_q;
        if (ld && i_enb) begin
            state_d     = TX;
            cnt_d       = 4'd0;
            start_d     = 1'b1;
            idle_d      = comma;
            sh_d        = hold_full_q ? hold_q : bypass ? sym : phase_q ? COMMA_POS : COMMA_NEG;
            hold_full_d = 1'b0;
            phase_d     = comma ? !phase_q : phase_q;
        end else if (ld) begin
            // line goes quiet after bit j; a queued symbol stays in HOLD
            state_d = OFF;
            cnt_d   = 4'd0;
            sh_d    = '0;
            idle_d  = 1'b0;
        end else if (state_q == TX) begin
            cnt_d = cnt_q + 4'd1;
            sh_d  = {sh_q[8:0], 1'b0};
        end
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= OFF;
            cnt_q       <= 4'd0;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            phase_q     <= 1'b0;
            start_q     <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            phase_q     <= phase_d;
            start_q     <= start_d;
            idle_q      <= idle_d;
        end
    end
    assign o_ready     = !hold_full_q;
    assign o_ser_bit   = sh_q[9];
    assign o_ser_valid = state_q == TX;
    assign o_sym_start = start_q;
    assign o_idle      = idle_q;
endmodule
